// File: rtl/nn_stream_pkg.sv
// rtl/nn_stream_pkg.sv - shared types and constants for the ones-stream generator
package nn_stream_pkg;

  localparam int W_DEFAULT = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_THERM  = 1'b0;
  localparam logic MODE_SPREAD = 1'b1;

endpackage

// File: rtl/ones_spreader.sv
// rtl/ones_spreader.sv - one step of the evenly-spread ones accumulator
module ones_spreader #(
  parameter int W = 11
) (
  input  logic [W:0]   acc_i,
  input  logic [W-1:0] count_i,
  input  logic [W-1:0] len_i,
  output logic         bit_o,
  output logic [W:0]   acc_o
);

  logic [W:0] sum;

  // acc < len and count <= len keep sum below 2*len, so W+1 bits never overflow
  always_comb begin
    sum = acc_i + {1'b0, count_i};
    if (sum >= {1'b0, len_i}) begin
      bit_o = 1'b1;
      acc_o = sum - {1'b0, len_i};
    end else begin
      bit_o = 1'b0;
      acc_o = sum;
    end
  end

endmodule

// File: rtl/one_stream_gen.sv
// rtl/one_stream_gen.sv - emits a serial stream of len bits holding count ones
module one_stream_gen
  import nn_stream_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] count,
  input  logic [W-1:0] len,
  input  logic         mode,
  input  logic         hold,
  output logic         a,
  output logic         ld,
  output logic         busy,
  output logic         done
);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] len_q, len_d;
  logic         mode_q, mode_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W:0]   acc_q, acc_d;
  logic         a_q, a_d;
  logic         ld_q, ld_d;

  logic         idle;
  logic [W-1:0] sat_count;
  logic [W-1:0] op_cnt, op_len, op_idx;
  logic         op_mode;
  logic [W:0]   op_acc;
  logic         spread_bit, next_bit;
  logic [W:0]   spread_acc;

  // In IDLE the first bit is computed straight from the inputs so ld rises one cycle after start
  always_comb begin
    idle      = (state_q == ST_IDLE);
    sat_count = (count > len) ? len : count;
    op_cnt    = idle ? sat_count : cnt_q;
    op_len    = idle ? len : len_q;
    op_mode   = idle ? mode : mode_q;
    op_acc    = idle ? '0 : acc_q;
    op_idx    = idle ? '0 : idx_q + 1'b1;
    next_bit  = (op_mode == MODE_SPREAD) ? spread_bit : (op_idx < op_cnt);
  end

  ones_spreader #(.W(W)) u_spreader (
    .acc_i   (op_acc),
    .count_i (op_cnt),
    .len_i   (op_len),
    .bit_o   (spread_bit),
    .acc_o   (spread_acc)
  );

  // idx_q is the index of the most recently emitted bit while in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    a_d     = 1'b0;
    ld_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d  = sat_count;
          len_d  = len;
          mode_d = mode;
          idx_d  = '0;
          acc_d  = '0;
          if (len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            ld_d    = 1'b1;
            a_d     = next_bit;
            acc_d   = spread_acc;
          end
        end
      end
      ST_RUN: begin
        if (idx_q == len_q - 1'b1) begin
          state_d = ST_DONE;
        end else if (!hold) begin
          ld_d  = 1'b1;
          a_d   = next_bit;
          idx_d = idx_q + 1'b1;
          acc_d = spread_acc;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      a_q     <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      ld_q    <= ld_d;
    end
  end

  assign a    = a_q;
  assign ld   = ld_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_one_stream_gen.sv
// tb/tb_one_stream_gen.sv - randomized self-checking bench for one_stream_gen
module tb_one_stream_gen;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] count;
  logic [W-1:0] len;
  logic         mode;
  logic         hold;
  logic         a;
  logic         ld;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  one_stream_gen #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .count (count),
    .len   (len),
    .mode  (mode),
    .hold  (hold),
    .a     (a),
    .ld    (ld),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit i of a stream: thermometer puts ones first, spread places bit i where floor(i*c/l) steps
  function automatic logic model_bit(input int c, input int l, input int m, input int i);
    longint cs;
    if (l == 0) return 1'b0;
    cs = (c > l) ? l : c;
    if (m == 0) return (i < cs);
    return ((longint'(i + 1) * cs) / l - (longint'(i) * cs) / l) != 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int c, input int l, input int m, input int hold_pct, input int stray_pct);
    int   cs;
    int   n;
    int   ones;
    int   bits;
    logic exp_ld, exp_done, h, finished;
    cs       = (c > l) ? l : c;
    n        = 0;
    ones     = 0;
    bits     = 0;
    finished = 1'b0;
    start    = 1'b1;
    count    = W'(c);
    len      = W'(l);
    mode     = m[0];
    hold     = ($urandom_range(99) < hold_pct);
    tick;
    start    = 1'b0;
    exp_ld   = (l > 0);
    exp_done = (l == 0);
    for (int cyc = 0; cyc < 4 * l + 20; cyc++) begin
      check("ld", ld, exp_ld);
      check("a", a, exp_ld ? model_bit(c, l, m, n) : 1'b0);
      check("done", done, exp_done);
      check("busy", busy, 1'b1);
      if (ld) begin
        bits++;
        if (a) ones++;
      end
      if (exp_done) begin
        finished = 1'b1;
        break;
      end
      if (exp_ld) n++;
      h    = ($urandom_range(99) < hold_pct);
      hold = h;
      if ($urandom_range(99) < stray_pct) begin
        start = 1'b1;
        count = W'($urandom_range(60));
        len   = W'($urandom_range(60));
        mode  = 1'($urandom_range(1));
      end else begin
        start = 1'b0;
      end
      if (n == l) begin
        exp_ld   = 1'b0;
        exp_done = 1'b1;
      end else begin
        exp_ld   = !h;
        exp_done = 1'b0;
      end
      tick;
    end
    check("stream_finished", finished, 1'b1);
    start = 1'b0;
    hold  = 1'b0;
    check("ones_total", ones, cs);
    check("ld_total", bits, l);
    tick;
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_ld", ld, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    count = '0;
    len   = '0;
    mode  = 1'b0;
    repeat (3) tick;
    check("rst_a", a, 1'b0);
    check("rst_ld", ld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    run_stream(3, 5, 0, 0, 0);
    run_stream(3, 8, 1, 0, 0);
    run_stream(9, 4, 0, 0, 0);
    run_stream(5, 0, 0, 0, 0);
    run_stream(2, 4, 0, 40, 50);
    run_stream(1000, 2047, 1, 10, 5);
    run_stream(2047, 2047, 0, 0, 0);

    // Abort after the second bit: reset must win and suppress done
    start = 1'b1;
    count = W'(3);
    len   = W'(6);
    mode  = 1'b0;
    tick;
    start = 1'b0;
    check("abort_bit1", ld, 1'b1);
    tick;
    check("abort_bit2", ld, 1'b1);
    rst = 1'b1;
    start = 1'b1;
    tick;
    check("abort_a", a, 1'b0);
    check("abort_ld", ld, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    run_stream(1, 1, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      run_stream($urandom_range(50), $urandom_range(40), $urandom_range(1), $urandom_range(50), 20);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
